// File: rtl/sdiv_datapath_if.sv
// sdiv_datapath_if: strobe/operand/result bundle for the divider.
// master drives Load/Shift/Sub/Compare/Enable and operands; slave returns results.
interface sdiv_datapath_if #(
  parameter int N = 8
) ();

  logic         Load;
  logic         Shift;
  logic         Sub;
  logic         Compare;
  logic         Enable;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         End;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         done;
  logic         div0;

  modport master (
    output Load,
    output Shift,
    output Sub,
    output Compare,
    output Enable,
    output dividend,
    output divisor,
    input  End,
    input  quotient,
    input  remainder,
    input  done,
    input  div0
  );

  modport slave (
    input  Load,
    input  Shift,
    input  Sub,
    input  Compare,
    input  Enable,
    input  dividend,
    input  divisor,
    output End,
    output quotient,
    output remainder,
    output done,
    output div0
  );

endinterface

// File: rtl/sdiv_datapath.sv
// sdiv_datapath: strobe-driven restoring unsigned divider datapath.
// Ports: clk, reset (async, active-high), bus (sdiv_datapath_if.slave).
module sdiv_datapath #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  sdiv_datapath_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  logic [N:0]    a_q;
  logic [N:0]    a_d;
  logic [N-1:0]  q_q;
  logic [N-1:0]  q_d;
  logic [N-1:0]  m_q;
  logic [N-1:0]  m_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          busy_q;
  logic          busy_d;
  logic          done_q;
  logic          done_d;
  logic          dz_q;
  logic          dz_d;

  logic          fin;
  logic [N:0]    m_ext;
  logic [N:0]    a_sub;
  logic [N:0]    a_add;

  assign fin   = busy_q && (cnt_q == '0);
  assign m_ext = {1'b0, m_q};
  assign a_sub = a_q - m_ext;
  assign a_add = a_q + m_ext;

  // A/Q/M update: Load wins, then Shift, Sub, Compare.
  always_comb begin
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    if (bus.Load) begin
      a_d = '0;
      q_d = bus.dividend;
      m_d = bus.divisor;
    end else if (bus.Shift) begin
      {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
    end else if (bus.Sub) begin
      a_d = a_sub;
    end else if (bus.Compare) begin
      // A[N] set means the trial subtraction went negative.
      if (a_q[N]) begin
        a_d    = a_add;
        q_d[0] = 1'b0;
      end else begin
        q_d[0] = 1'b1;
      end
    end
  end

  // Counter and status; Load overrides everything here too.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    dz_d   = dz_q;
    if (bus.Load) begin
      cnt_d  = CW'(N);
      busy_d = 1'b1;
      done_d = 1'b0;
      dz_d   = (bus.divisor == '0);
    end else begin
      // Saturate at zero rather than wrapping.
      if (bus.Enable && (cnt_q != '0)) begin
        cnt_d = cnt_q - CW'(1);
      end
      if (fin) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign bus.End       = fin;
  assign bus.quotient  = q_q;
  assign bus.remainder = a_q[N-1:0];
  assign bus.done      = done_q;
  assign bus.div0      = dz_q;

endmodule

// File: tb/tb_sdiv_datapath.sv
// tb_sdiv_datapath: random divisions against an arithmetic reference.
// Drives strobes at negedge, samples outputs at negedge.
module tb_sdiv_datapath;

  localparam int N = 8;

  localparam logic [4:0] S_NO = 5'b00000;
  localparam logic [4:0] S_LD = 5'b10000;
  localparam logic [4:0] S_SH = 5'b01000;
  localparam logic [4:0] S_SB = 5'b00100;
  localparam logic [4:0] S_CP = 5'b00010;
  localparam logic [4:0] S_EN = 5'b00001;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdiv_datapath_if #(.N(N)) bus ();

  sdiv_datapath #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [4:0] s);
    {bus.Load, bus.Shift, bus.Sub, bus.Compare, bus.Enable} = s;
    @(posedge clk);
    @(negedge clk);
    {bus.Load, bus.Shift, bus.Sub, bus.Compare, bus.Enable} = S_NO;
  endtask

  function automatic logic [4:0] nominal(input int i);
    case (i % 3)
      0:       return S_SH;
      1:       return S_SB;
      default: return S_CP | S_EN;
    endcase
  endfunction

  // Extra lower-priority strobes that must be ignored.
  function automatic logic [4:0] noisy(input int i);
    logic [4:0] s;
    s = nominal(i);
    if (i % 3 == 0) begin
      if ($urandom_range(1) == 1) s = s | S_SB;
      if ($urandom_range(1) == 1) s = s | S_CP;
    end else if (i % 3 == 1) begin
      if ($urandom_range(1) == 1) s = s | S_CP;
    end
    return s;
  endfunction

  task automatic partial(input int d, input int v, input int steps);
    bus.dividend = N'(d);
    bus.divisor  = N'(v);
    tick(S_LD);
    for (int i = 0; i < steps; i++) tick(nominal(i));
  endtask

  task automatic run_div(input string tag,
                         input int d,
                         input int v,
                         input int gap_pct,
                         input bit mix,
                         input logic [4:0] ld_extra);
    int cyc_n;
    int gaps;
    logic [N-1:0] eq;
    logic [N-1:0] er;
    if (v == 0) begin
      eq = '1;
      er = N'(d);
    end else begin
      eq = N'(d / v);
      er = N'(d % v);
    end
    bus.dividend = N'(d);
    bus.divisor  = N'(v);
    tick(S_LD | ld_extra);
    cyc_n = 1;
    gaps  = 0;
    chk({tag, " q@load"}, 32'(bus.quotient), 32'(d));
    chk({tag, " r@load"}, 32'(bus.remainder), 0);
    chk({tag, " done@load"}, 32'(bus.done), 0);
    chk({tag, " div0@load"}, 32'(bus.div0), 32'(v == 0));
    for (int i = 0; i < 3 * N; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        chk({tag, " End gap"}, 32'(bus.End), 0);
        tick(S_NO);
        cyc_n++;
        gaps++;
      end
      chk({tag, " End busy"}, 32'(bus.End), 0);
      tick(mix ? noisy(i) : nominal(i));
      cyc_n++;
    end
    chk({tag, " End"}, 32'(bus.End), 1);
    chk({tag, " End cycle"}, 32'(cyc_n), 32'(3 * N + 1 + gaps));
    chk({tag, " done pre"}, 32'(bus.done), 0);
    tick(S_EN);
    chk({tag, " End after"}, 32'(bus.End), 0);
    chk({tag, " done"}, 32'(bus.done), 1);
    chk({tag, " quot"}, 32'(bus.quotient), 32'(eq));
    chk({tag, " rem"}, 32'(bus.remainder), 32'(er));
    chk({tag, " div0"}, 32'(bus.div0), 32'(v == 0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " q"}, 32'(bus.quotient), 0);
    chk({tag, " r"}, 32'(bus.remainder), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " div0"}, 32'(bus.div0), 0);
    chk({tag, " End"}, 32'(bus.End), 0);
  endtask

  initial begin
    logic [N-1:0] hq;
    logic [N-1:0] hr;
    {bus.Load, bus.Shift, bus.Sub, bus.Compare, bus.Enable} = S_NO;
    bus.dividend = '0;
    bus.divisor  = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    run_div("100/7", 100, 7, 0, 0, S_NO);
    run_div("255/1", 255, 1, 0, 0, S_NO);
    run_div("5/9", 5, 9, 0, 0, S_NO);
    run_div("200/0", 200, 0, 0, 0, S_NO);

    // Async reset clears sticky done/div0 without a clock edge.
    #2 reset = 1'b1;
    #1 check_zero("rst div0");
    @(negedge clk);
    reset = 1'b0;

    // Reset during iteration 4 of 100/7.
    partial(100, 7, 10);
    #2 reset = 1'b1;
    #1 check_zero("rst mid");
    @(negedge clk);
    reset = 1'b0;
    run_div("50/6", 50, 6, 0, 0, S_NO);

    // Idle: End low, results and done held.
    hq = bus.quotient;
    hr = bus.remainder;
    for (int i = 0; i < 6; i++) begin
      tick(S_NO);
      chk("idle End", 32'(bus.End), 0);
      chk("idle done", 32'(bus.done), 1);
      chk("idle q", 32'(bus.quotient), 32'(hq));
      chk("idle r", 32'(bus.remainder), 32'(hr));
    end

    // Load with Shift+Enable: only the Load takes effect.
    run_div("ld+sh+en", 173, 11, 0, 0, S_SH | S_EN);

    // Abort a running division with a fresh Load.
    partial(99, 4, 13);
    run_div("abort", 77, 5, 0, 0, S_NO);

    for (int k = 0; k < 24; k++) begin
      int d;
      int v;
      logic [4:0] ex;
      d = int'($urandom_range(255));
      v = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255));
      ex = 5'($urandom_range(15));
      if ($urandom_range(3) == 0) partial(int'($urandom_range(255)), 3,
                                          int'($urandom_range(20)));
      run_div($sformatf("rnd%0d", k), d, v, 20, 1, ex);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
